// File: rtl/lii_phy_out_arbiter.sv
// -----------------------------------------------------------------------------
// lii_phy_out_arbiter
//
// Shares one LII physical output channel between N packed logical requesters.
// Arbitration is round-robin with burst locking: once a requester wins, it
// keeps the channel until it sends a beat with tlast, or until it has sent
// MAXBURST beats, whichever comes first. Beats go out through a one-deep
// registered output stage that also carries a fixed source ID and a
// per-requester destination ID.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where tvalid and tready are both high. A source that raises tvalid holds
// tdata/tlast stable until that transfer. The output register holds
// lii_out_tdata/lii_out_dst stable while lii_out_tvalid=1 and lii_out_tready=0.
//
// Ports:
//   aclk            clock
//   arst            asynchronous active-high reset
//   req_tdata       N*PW requester data, requester i at [PW*i+PW-1:PW*i]
//   req_tvalid      N    per-requester valid
//   req_tlast       N    per-requester end-of-burst marker
//   req_tready      N    per-requester ready (only the granted bit can be high)
//   lii_out_tdata   PW   phy data
//   lii_out_tvalid  1    phy valid
//   lii_out_tready  1    phy ready
//   lii_out_src     8    source ID (constant SRC_ID)
//   lii_out_dst     8    destination ID of the beat currently on lii_out
//   grant           N    one-hot current grant, all-zero in IDLE
//   busy            1    high in GRANT or while lii_out_tvalid=1
// -----------------------------------------------------------------------------
module lii_phy_out_arbiter #(
    parameter int             N        = 4,
    parameter int             PW       = 64,
    parameter logic [7:0]     SRC_ID   = 8'd0,
    parameter logic [N*8-1:0] DST_IDS  = {N{8'd0}},
    parameter int             MAXBURST = 16
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [N*PW-1:0] req_tdata,
    input  logic [N-1:0]    req_tvalid,
    input  logic [N-1:0]    req_tlast,
    output logic [N-1:0]    req_tready,
    output logic [PW-1:0]   lii_out_tdata,
    output logic            lii_out_tvalid,
    input  logic            lii_out_tready,
    output logic [7:0]      lii_out_src,
    output logic [7:0]      lii_out_dst,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(MAXBURST + 1);

    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N - 1);
    // Counter value on the beat that completes a MAXBURST-long grant.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXBURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [N-1:0]      grant_r;
    logic [PTR_W-1:0]  ptr;        // last winner; also the index of the live grant
    logic [CNT_W-1:0]  cnt;        // beats accepted in the current grant

    logic              out_valid;
    logic [PW-1:0]     out_data;
    logic [7:0]        out_dst;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;

    logic              slot_free;
    logic              g_valid;
    logic              g_last;
    logic [PW-1:0]     g_data;
    logic [7:0]        g_dst;
    logic              accept;
    logic              rel_beat;

    // -------------------------------------------------------------------------
    // Round-robin search: first requester with tvalid, starting at ptr+1 and
    // wrapping modulo N. The wrap is done by subtraction so N need not be a
    // power of two.
    // -------------------------------------------------------------------------
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 1; k <= N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!win_found && req_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Granted-requester view. While in GRANT, ptr names the granted requester,
    // so all per-requester selection is a simple index by ptr.
    // -------------------------------------------------------------------------
    assign g_valid = req_tvalid[ptr];
    assign g_last  = req_tlast[ptr];
    assign g_data  = req_tdata[int'(ptr) * PW +: PW];
    assign g_dst   = DST_IDS[int'(ptr) * 8 +: 8];

    // The output register can take a beat when empty or when its current beat
    // leaves on this same edge.
    assign slot_free = !out_valid || lii_out_tready;

    assign accept   = (state == S_GRANT) && g_valid && slot_free;
    // tlast and the burst limit on the same beat give a single release.
    assign rel_beat = accept && (g_last || (cnt == CNT_LAST));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // Bubbles on the granted requester keep the grant.
                if (rel_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_tready = '0;
        if (state == S_GRANT) begin
            req_tready[ptr] = slot_free;
        end
    end

    assign busy  = (state == S_GRANT) || out_valid;
    assign grant = grant_r;

    // -------------------------------------------------------------------------
    // Grant, round-robin pointer and burst counter
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            grant_r <= '0;
            ptr     <= PTR_RST;
            cnt     <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (win_found) begin
                    grant_r <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                    ptr     <= win_idx;
                    cnt     <= '0;
                end
            end else if (accept) begin
                if (rel_beat) begin
                    grant_r <= '0;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // One-deep output register. A new accept and a drain on the same edge
    // simply replace the beat, so throughput is one beat per cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dst   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_dst   <= g_dst;
            end else if (lii_out_tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign lii_out_tvalid = out_valid;
    assign lii_out_tdata  = out_data;
    assign lii_out_dst    = out_dst;
    assign lii_out_src    = SRC_ID;

endmodule

// File: tb/tb_lii_phy_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lii_phy_out_arbiter
//
// Each traffic run loads a per-requester list of beats. A reference model
// walks those lists with the round-robin / burst rules and produces the
// expected grant order and the expected stream of (data, dst) on lii_out.
// Drivers keep every requester with pending beats valid, except that the
// granted requester may insert bubbles, so the set of contenders at every
// arbitration point equals "requesters with beats left".
// -----------------------------------------------------------------------------
module tb_lii_phy_out_arbiter;

    localparam int             N       = 4;
    localparam int             PW      = 64;
    localparam logic [7:0]     SRC_ID  = 8'hA5;
    localparam logic [N*8-1:0] DST_IDS = {8'h44, 8'h05, 8'h22, 8'h11};
    localparam int             MAXB    = 4;
    localparam int             MAXQ    = 32;

    // ---------------------------------------------------------------- clock/reset
    logic            aclk = 1'b0;
    logic            arst;
    logic [N*PW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tlast;
    logic [N-1:0]    req_tready;
    logic [PW-1:0]   lii_out_tdata;
    logic            lii_out_tvalid;
    logic            lii_out_tready;
    logic [7:0]      lii_out_src;
    logic [7:0]      lii_out_dst;
    logic [N-1:0]    grant;
    logic            busy;

    always #5 aclk = ~aclk;

    lii_phy_out_arbiter #(
        .N        (N),
        .PW       (PW),
        .SRC_ID   (SRC_ID),
        .DST_IDS  (DST_IDS),
        .MAXBURST (MAXB)
    ) dut (
        .aclk           (aclk),
        .arst           (arst),
        .req_tdata      (req_tdata),
        .req_tvalid     (req_tvalid),
        .req_tlast      (req_tlast),
        .req_tready     (req_tready),
        .lii_out_tdata  (lii_out_tdata),
        .lii_out_tvalid (lii_out_tvalid),
        .lii_out_tready (lii_out_tready),
        .lii_out_src    (lii_out_src),
        .lii_out_dst    (lii_out_dst),
        .grant          (grant),
        .busy           (busy)
    );

    // ---------------------------------------------------------------- checking
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- stimulus store
    logic [PW-1:0] bd [N][MAXQ];
    logic          bl [N][MAXQ];
    int            nb [N];
    int            idx [N];

    int ready_pct;
    int bubble_pct;
    int stall_start;
    int stall_len;
    int force_req;
    int force_idx;
    int force_len;

    // ---------------------------------------------------------------- scoreboard
    logic [PW-1:0] exp_q[$];
    logic [7:0]    exp_dst_q[$];
    logic [N-1:0]  exp_gnt_q[$];
    int            mptr;   // last winner, as the arbitration rules define it

    // Reference model: round-robin over requesters that still have beats,
    // each grant lasting until tlast or MAXB beats.
    function automatic void build_expected();
        int           m [N];
        int           w;
        int           cnt;
        bit           found;
        bit           last;
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) m[i] = 0;
        w     = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c = (mptr + k) % N;
                if (!found && m[c] < nb[c]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            if (found) begin
                mptr  = w;
                oh    = '0;
                oh[w] = 1'b1;
                exp_gnt_q.push_back(oh);
                cnt  = 0;
                last = 1'b0;
                while (!last && cnt < MAXB && m[w] < nb[w]) begin
                    exp_q.push_back(bd[w][m[w]]);
                    exp_dst_q.push_back(DST_IDS[w*8 +: 8]);
                    last = bl[w][m[w]];
                    m[w]++;
                    cnt++;
                end
            end
        end
    endfunction

    // ---------------------------------------------------------------- driver tasks
    task automatic clear_lists();
        for (int i = 0; i < N; i++) begin
            nb[i] = 0;
            for (int k = 0; k < MAXQ; k++) begin
                bd[i][k] = '0;
                bl[i][k] = 1'b0;
            end
        end
        ready_pct   = 100;
        bubble_pct  = 0;
        stall_start = 0;
        stall_len   = 0;
        force_req   = 0;
        force_idx   = 0;
        force_len   = 0;
    endtask

    // Fill requester i with n beats; tlast only on the final one.
    task automatic fill_req(input int i, input int n, input int tag);
        nb[i] = n;
        for (int k = 0; k < n; k++) begin
            bd[i][k] = {8'(i), 8'(tag), 8'(k), 8'h00, $urandom};
            bl[i][k] = (k == n - 1);
        end
    endtask

    task automatic set_inputs(input int cyc);
        for (int i = 0; i < N; i++) begin
            if (idx[i] < nb[i]) begin
                req_tdata[i*PW +: PW] = bd[i][idx[i]];
                req_tlast[i]          = bl[i][idx[i]];
                if (grant[i]) begin
                    if (i == force_req && idx[i] == force_idx && force_len > 0) begin
                        req_tvalid[i] = 1'b0;
                        force_len--;
                    end else begin
                        req_tvalid[i] = ($urandom_range(99, 0) >= bubble_pct);
                    end
                end else begin
                    req_tvalid[i] = 1'b1;
                end
            end else begin
                req_tdata[i*PW +: PW] = '0;
                req_tlast[i]          = 1'b0;
                req_tvalid[i]         = 1'b0;
            end
        end
        if (cyc >= stall_start && cyc < stall_start + stall_len) begin
            lii_out_tready = 1'b0;
        end else begin
            lii_out_tready = ($urandom_range(99, 0) < ready_pct);
        end
    endtask

    // Drive the loaded lists to completion and check everything on the way.
    task automatic run_traffic(input int max_cycles);
        logic [N-1:0]  prev_grant;
        logic [N-1:0]  fired;
        logic [N-1:0]  exp_rdy;
        bit            prev_stall;
        bit            prev_any;
        bit            pend;
        logic [PW-1:0] pend_data;
        logic [PW-1:0] prev_data;
        logic [7:0]    prev_dst;
        int            cyc;

        build_expected();
        for (int i = 0; i < N; i++) idx[i] = 0;
        prev_grant = grant;
        prev_stall = 1'b0;
        prev_any   = 1'b0;
        pend       = 1'b0;
        pend_data  = '0;
        prev_data  = '0;
        prev_dst   = '0;
        cyc        = 0;
        set_inputs(cyc);

        while (exp_q.size() != 0 && cyc < max_cycles) begin
            @(negedge aclk);
            if (pend) begin
                check("latency_valid", PW'(lii_out_tvalid), PW'(1'b1));
                check("latency_data", lii_out_tdata, pend_data);
            end
            if (prev_stall) begin
                check("hold_valid", PW'(lii_out_tvalid), PW'(1'b1));
                check("hold_data", lii_out_tdata, prev_data);
                check("hold_dst", PW'(lii_out_dst), PW'(prev_dst));
            end
            if (lii_out_tvalid && lii_out_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", PW'(1'b1), PW'(1'b0));
                end else begin
                    check("out_data", lii_out_tdata, exp_q.pop_front());
                    check("out_dst", PW'(lii_out_dst), PW'(exp_dst_q.pop_front()));
                end
            end
            check("out_src", PW'(lii_out_src), PW'(SRC_ID));
            check("grant_onehot", PW'($onehot0(grant)), PW'(1'b1));
            if (prev_grant != '0 && grant != '0) begin
                check("grant_hold", PW'(grant), PW'(prev_grant));
            end
            if (prev_grant == '0 && grant != '0) begin
                if (exp_gnt_q.size() == 0) begin
                    check("extra_grant", PW'(grant), PW'(1'b0));
                end else begin
                    check("grant_order", PW'(grant), PW'(exp_gnt_q.pop_front()));
                end
            end
            if (prev_grant == '0 && prev_any) begin
                check("idle_one_cycle", PW'(grant != '0), PW'(1'b1));
            end
            exp_rdy = grant & {N{(!lii_out_tvalid || lii_out_tready)}};
            check("req_tready", PW'(req_tready), PW'(exp_rdy));
            check("busy", PW'(busy), PW'((grant != '0) || lii_out_tvalid));

            fired = req_tvalid & req_tready;
            pend  = (fired != '0);
            for (int i = 0; i < N; i++) begin
                if (fired[i]) pend_data = bd[i][idx[i]];
            end
            prev_stall = lii_out_tvalid && !lii_out_tready;
            prev_data  = lii_out_tdata;
            prev_dst   = lii_out_dst;
            prev_grant = grant;
            prev_any   = (req_tvalid != '0);

            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fired[i]) idx[i]++;
            end
            cyc++;
            set_inputs(cyc);
        end

        check("run_in_budget", PW'(cyc < max_cycles), PW'(1'b1));
        check("beats_left", PW'(exp_q.size()), PW'(0));
        check("grants_left", PW'(exp_gnt_q.size()), PW'(0));
        exp_q.delete();
        exp_dst_q.delete();
        exp_gnt_q.delete();
    endtask

    task automatic expect_idle(input string tag);
        @(negedge aclk);
        check({tag, "_grant"}, PW'(grant), PW'(0));
        check({tag, "_tvalid"}, PW'(lii_out_tvalid), PW'(0));
        check({tag, "_busy"}, PW'(busy), PW'(0));
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        arst           = 1'b1;
        req_tvalid     = '0;
        req_tlast      = '0;
        req_tdata      = '0;
        lii_out_tready = 1'b0;
        mptr           = N - 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main sequence
    initial begin
        arst           = 1'b1;
        req_tvalid     = '0;
        req_tlast      = '0;
        req_tdata      = '0;
        lii_out_tready = 1'b0;
        mptr           = N - 1;
        clear_lists();
        for (int i = 0; i < N; i++) idx[i] = 0;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_grant", PW'(grant), PW'(0));
        check("rst_req_tready", PW'(req_tready), PW'(0));
        check("rst_tvalid", PW'(lii_out_tvalid), PW'(0));
        check("rst_tdata", lii_out_tdata, PW'(0));
        check("rst_dst", PW'(lii_out_dst), PW'(0));
        check("rst_src", PW'(lii_out_src), PW'(SRC_ID));
        check("rst_busy", PW'(busy), PW'(0));
        @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk);
        #1;

        // All four requesters continuously valid, no early tlast: 0,1,2,3,0,1,2,3
        clear_lists();
        for (int i = 0; i < N; i++) fill_req(i, 8, 1);
        run_traffic(200);
        expect_idle("all4_end");

        // Only requester 2: three beats 0xA, 0xB, 0xC, tlast on 0xC
        clear_lists();
        nb[2]    = 3;
        bd[2][0] = 64'hA;
        bd[2][1] = 64'hB;
        bd[2][2] = 64'hC;
        bl[2][2] = 1'b1;
        run_traffic(50);
        expect_idle("req2_end");

        // Requester 0 bursting with lii_out_tready low for 5 cycles mid-burst
        clear_lists();
        fill_req(0, 10, 3);
        stall_start = 3;
        stall_len   = 5;
        run_traffic(100);
        expect_idle("stall_end");

        // tlast on beat 4 coinciding with the burst limit
        clear_lists();
        fill_req(0, 6, 4);
        bl[0][3] = 1'b1;
        fill_req(1, 6, 4);
        bl[1][2] = 1'b1;
        run_traffic(100);
        expect_idle("tlast_max_end");

        // Granted requester 1 drops tvalid for 3 cycles while requester 3 waits
        clear_lists();
        fill_req(1, 6, 5);
        fill_req(3, 3, 5);
        force_req = 1;
        force_idx = 1;
        force_len = 3;
        run_traffic(100);
        expect_idle("bubble_end");

        // Reset mid-burst of requester 2 with a beat held in the output register
        clear_lists();
        req_tvalid            = 4'b0100;
        req_tdata[2*PW +: PW] = 64'h77;
        req_tlast             = '0;
        lii_out_tready        = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("pre_rst_grant", PW'(grant), PW'(4'b0100));
        check("pre_rst_tvalid", PW'(lii_out_tvalid), PW'(1'b1));
        #2;
        arst = 1'b1;
        #1;
        check("mid_rst_tvalid", PW'(lii_out_tvalid), PW'(0));
        check("mid_rst_grant", PW'(grant), PW'(0));
        check("mid_rst_tdata", lii_out_tdata, PW'(0));
        check("mid_rst_dst", PW'(lii_out_dst), PW'(0));
        check("mid_rst_req_tready", PW'(req_tready), PW'(0));
        req_tvalid     = '1;
        lii_out_tready = 1'b1;
        @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk);
        #1;
        check("post_rst_first_grant", PW'(grant), PW'(4'b0001));
        apply_reset();

        // Randomized traffic
        for (int r = 0; r < 12; r++) begin
            clear_lists();
            for (int i = 0; i < N; i++) begin
                nb[i] = $urandom_range(10, 0);
                for (int k = 0; k < nb[i]; k++) begin
                    bd[i][k] = {8'(i), 8'(r + 16), 8'(k), 8'h00, $urandom};
                    bl[i][k] = ($urandom_range(3, 0) == 0) || (k == nb[i] - 1);
                end
            end
            ready_pct   = $urandom_range(100, 30);
            bubble_pct  = $urandom_range(40, 0);
            stall_start = $urandom_range(30, 0);
            stall_len   = $urandom_range(6, 0);
            run_traffic(2000);
            expect_idle("rand_end");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
